// File: rtl/joy_splitter_ctrl_if.sv
// Signal bundle between the joystick splitter scheduler and its environment.
// The slave modport is the scheduler; the master modport is the side that drives the pins.
interface joy_splitter_ctrl_if;
    logic       splitter_en;
    logic [4:0] joy_in;
    logic       joyselect;
    logic [4:0] joystick1;
    logic [4:0] joystick2;
    logic       scan_done;

    modport master (
        output splitter_en, joy_in,
        input  joyselect, joystick1, joystick2, scan_done
    );

    modport slave (
        input  splitter_en, joy_in,
        output joyselect, joystick1, joystick2, scan_done
    );
endinterface

// File: rtl/joy_splitter_ctrl.sv
// Two-port joystick splitter scheduler: alternates joyselect, settles, samples pins per port.
// Optional feature macro: JOY_SPLITTER_DEBOUNCE_EN (two-scan agreement filter per port bit).
module joy_splitter_ctrl #(
    parameter int unsigned PHASE_CYCLES  = 64,
    parameter int unsigned SETTLE_CYCLES = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    joy_splitter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        P1_SETTLE = 2'd0,
        P1_HOLD   = 2'd1,
        P2_SETTLE = 2'd2,
        P2_HOLD   = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT   = 16'(PHASE_CYCLES - 1);
    localparam logic [15:0] SETTLE_CNT = 16'(SETTLE_CYCLES - 1);
    localparam logic [4:0]  JOY_IDLE   = 5'h1F;

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic        w_phase_end;
    logic        w_settle_end;
    logic        w_cnt_clr;
    logic        w_take1;
    logic        w_take2;
    logic        w_scan_pulse;
    logic        w_sel_nxt;
    logic        r_sel;
    logic        r_scan_done;
    logic [4:0]  r_joy1;
    logic [4:0]  r_joy2;

    // NOTE: reset asserts asynchronously but releases two edges later, synchronous to clk,
    // so no flop leaves reset on a different edge than its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= JOY_IDLE;
            r_sync2 <= JOY_IDLE;
        end else begin
            r_sync1 <= bus.joy_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_phase_end  = (r_cnt == LAST_CNT);
    assign w_settle_end = (r_cnt == SETTLE_CNT);
    assign w_cnt_clr    = (w_state_nxt != r_state) &&
                          (w_state_nxt == P1_SETTLE || w_state_nxt == P2_SETTLE);

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= P1_SETTLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + 16'd1;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            P1_SETTLE: if (w_settle_end) w_state_nxt = P1_HOLD;
            P1_HOLD:   if (w_phase_end)  w_state_nxt = bus.splitter_en ? P2_SETTLE : P1_SETTLE;
            P2_SETTLE: if (w_settle_end) w_state_nxt = P2_HOLD;
            P2_HOLD:   if (w_phase_end)  w_state_nxt = P1_SETTLE;
            default:                     w_state_nxt = P1_SETTLE;
        endcase
    end

    always_comb begin
        w_take1      = 1'b0;
        w_take2      = 1'b0;
        w_scan_pulse = 1'b0;
        w_sel_nxt    = r_sel;
        case (r_state)
            P1_SETTLE: w_take1 = w_settle_end;
            P1_HOLD: begin
                if (w_phase_end) begin
                    if (bus.splitter_en) w_sel_nxt    = 1'b0;
                    else                 w_scan_pulse = 1'b1;
                end
            end
            P2_SETTLE: w_take2 = w_settle_end;
            P2_HOLD: begin
                if (w_phase_end) begin
                    w_scan_pulse = 1'b1;
                    w_sel_nxt    = 1'b1;
                end
            end
            default: w_sel_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sel       <= 1'b1;
            r_scan_done <= 1'b0;
        end else begin
            r_sel       <= w_sel_nxt;
            r_scan_done <= w_scan_pulse;
        end
    end

`ifdef JOY_SPLITTER_DEBOUNCE_EN
    logic [4:0] r_prev1;
    logic [4:0] r_prev2;

    // A bit moves only when this sample matches the previous sample of the same port.
    function automatic logic [4:0] debounce(input logic [4:0] cur, input logic [4:0] prev,
                                            input logic [4:0] out);
        logic [4:0] agree;
        agree = ~(cur ^ prev);
        return (cur & agree) | (out & ~agree);
    endfunction

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_joy1  <= JOY_IDLE;
            r_joy2  <= JOY_IDLE;
            r_prev1 <= JOY_IDLE;
            r_prev2 <= JOY_IDLE;
        end else begin
            if (w_take1) begin
                r_joy1  <= debounce(r_sync2, r_prev1, r_joy1);
                r_prev1 <= r_sync2;
            end
            if (!bus.splitter_en) begin
                r_joy2  <= JOY_IDLE;
                r_prev2 <= JOY_IDLE;
            end else if (w_take2) begin
                r_joy2  <= debounce(r_sync2, r_prev2, r_joy2);
                r_prev2 <= r_sync2;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_joy1 <= JOY_IDLE;
            r_joy2 <= JOY_IDLE;
        end else begin
            if (w_take1) r_joy1 <= r_sync2;
            if (!bus.splitter_en) r_joy2 <= JOY_IDLE;
            else if (w_take2)     r_joy2 <= r_sync2;
        end
    end
`endif

    assign bus.joyselect = r_sel;
    assign bus.scan_done = r_scan_done;
    assign bus.joystick1 = r_joy1;
    assign bus.joystick2 = r_joy2;

endmodule

// File: tb/tb_joy_splitter_ctrl.sv
// Randomised self-checking bench for joy_splitter_ctrl against a phase-timeline reference model.
module tb_joy_splitter_ctrl;

    localparam int P = 64;
    localparam int S = 24;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    joy_splitter_ctrl_if jif ();

    joy_splitter_ctrl #(
        .PHASE_CYCLES (P),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (jif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: which port is being served and how far into its phase we are.
    int         m_wait;
    int         m_port;
    int         m_t;
    logic       m_sel;
    logic       m_done;
    logic [4:0] m_j1, m_j2, m_prev1, m_prev2;
    logic [4:0] m_hist[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_wait  = 0;
        m_port  = 1;
        m_t     = 0;
        m_sel   = 1'b1;
        m_done  = 1'b0;
        m_j1    = 5'h1F;
        m_j2    = 5'h1F;
        m_prev1 = 5'h1F;
        m_prev2 = 5'h1F;
        m_hist  = {5'h1F, 5'h1F};
    endtask

    function automatic logic [4:0] take_sample(input logic [4:0] s, input logic [4:0] prev,
                                               input logic [4:0] out);
        logic [4:0] r;
        r = s;
`ifdef JOY_SPLITTER_DEBOUNCE_EN
        r = out;
        for (int b = 0; b < 5; b++) if (s[b] == prev[b]) r[b] = s[b];
`endif
        return r;
    endfunction

    // One rising clock edge with the given inputs applied.
    task automatic model_step(input bit en, input logic [4:0] joy);
        logic [4:0] sval;
        if (!reset_n) return;
        if (m_wait > 0) begin
            m_wait--;
            return;
        end
        sval   = m_hist.pop_front();
        m_hist.push_back(joy);
        m_done = 1'b0;
        if (m_t == S - 1) begin
            if (m_port == 1) begin
                m_j1    = take_sample(sval, m_prev1, m_j1);
                m_prev1 = sval;
            end else begin
                m_j2    = take_sample(sval, m_prev2, m_j2);
                m_prev2 = sval;
            end
        end
        if (m_t == P - 1) begin
            if (m_port == 1 && en) begin
                m_port = 2;
                m_sel  = 1'b0;
            end else begin
                m_port = 1;
                m_sel  = 1'b1;
                m_done = 1'b1;
            end
            m_t = 0;
        end else begin
            m_t++;
        end
        if (!en) begin
            m_j2    = 5'h1F;
            m_prev2 = 5'h1F;
        end
    endtask

    task automatic compare_outputs();
        check("joyselect", 32'(jif.joyselect), 32'(m_sel));
        check("joystick1", 32'(jif.joystick1), 32'(m_j1));
        check("joystick2", 32'(jif.joystick2), 32'(m_j2));
        check("scan_done", 32'(jif.scan_done), 32'(m_done));
    endtask

    task automatic tick(input bit en, input logic [4:0] joy);
        jif.splitter_en = en;
        jif.joy_in      = joy;
        model_step(en, joy);
        @(negedge clk);
        compare_outputs();
    endtask

    // Advance until the model reaches the given port/phase offset; a missed target is a failure.
    task automatic run_until(input int port, input int t, input bit en,
                             input logic [4:0] v1, input logic [4:0] v2);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * P; i++) begin
            if (m_port == port && m_t == t) begin
                found = 1'b1;
                break;
            end
            tick(en, m_sel ? v1 : v2);
        end
        check("phase_reached", 32'(found), 32'd1);
    endtask

    initial begin
        logic [4:0] v1, v2, joy;
        bit         en_r;

        reset_n         = 1'b0;
        jif.splitter_en = 1'b0;
        jif.joy_in      = 5'h1F;
        model_reset();
        repeat (3) @(negedge clk);
        compare_outputs();
        reset_n = 1'b1;
        m_wait  = 2;

        // Single-joystick mode, fire held.
        repeat (3 * P) tick(1'b0, 5'h1E);
        check("single_j1", 32'(jif.joystick1), 32'h1E);
        check("single_sel", 32'(jif.joyselect), 32'd1);

        // Splitter mode with distinct per-port values.
        repeat (8 * P) tick(1'b1, m_sel ? 5'h17 : 5'h1D);
        check("split_j1", 32'(jif.joystick1), 32'h17);
        check("split_j2", 32'(jif.joystick2), 32'h1D);

        // Port-1 value lingers for 10 cycles after the switch; it must not be sampled.
        for (int k = 0; k < 2; k++) begin
            run_until(2, 0, 1'b1, 5'h17, 5'h1B);
            repeat (10) tick(1'b1, 5'h17);
            repeat (P - 10) tick(1'b1, 5'h1B);
        end
        check("settle_j2", 32'(jif.joystick2), 32'h1B);

        // Random per-phase values, occasional noise and splitter_en flips.
        v1   = 5'h1F;
        v2   = 5'h1F;
        en_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (m_t == 0 && $urandom_range(1) == 0) begin
                v1 = 5'($urandom);
                v2 = 5'($urandom);
            end
            if ($urandom_range(199) == 0) en_r = ~en_r;
            joy = ($urandom_range(19) == 0) ? 5'($urandom) : (m_sel ? v1 : v2);
            tick(en_r, joy);
        end

        // splitter_en drops in the middle of P2_SETTLE.
        repeat (2 * P) tick(1'b1, m_sel ? 5'h17 : 5'h1D);
        run_until(2, 5, 1'b1, 5'h17, 5'h1D);
        tick(1'b0, 5'h1D);
        check("drop_j2_next", 32'(jif.joystick2), 32'h1F);
        repeat (3 * P) tick(1'b0, m_sel ? 5'h17 : 5'h1D);
        check("drop_j2_held", 32'(jif.joystick2), 32'h1F);
        check("drop_sel", 32'(jif.joyselect), 32'd1);

        // Asynchronous reset in the middle of P2_HOLD.
        repeat (2 * P) tick(1'b1, m_sel ? 5'h15 : 5'h0B);
        run_until(2, 40, 1'b1, 5'h15, 5'h0B);
        #3 reset_n = 1'b0;
        #1;
        check("arst_sel", 32'(jif.joyselect), 32'd1);
        check("arst_j1", 32'(jif.joystick1), 32'h1F);
        check("arst_j2", 32'(jif.joystick2), 32'h1F);
        check("arst_done", 32'(jif.scan_done), 32'd0);
        model_reset();
        @(negedge clk);
        compare_outputs();
        reset_n = 1'b1;
        m_wait  = 2;
        repeat (3 * P) tick(1'b1, m_sel ? 5'h15 : 5'h0B);

        // One-scan glitch on port 1, then the same value held for several scans.
        repeat (2 * P) tick(1'b0, 5'h1F);
        run_until(1, 0, 1'b0, 5'h1F, 5'h1F);
        repeat (P) tick(1'b0, 5'h0F);
`ifdef JOY_SPLITTER_DEBOUNCE_EN
        check("glitch_j1", 32'(jif.joystick1), 32'h1F);
`else
        check("glitch_j1", 32'(jif.joystick1), 32'h0F);
`endif
        repeat (2 * P) tick(1'b0, 5'h1F);
        repeat (3 * P) tick(1'b0, 5'h0F);
        check("held_j1", 32'(jif.joystick1), 32'h0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/joy_splitter_ctrl.md
Name: joy_splitter_ctrl

Overview:
Scheduler for the external two-port joystick splitter that shares one 5-bit joystick pin set.
- Drives joyselect to alternate the splitter between port 1 and port 2.
- Waits a settle time after each switch, then samples the synchronised pins into per-port registers for the samcoupe joystick inputs.
- Runs on the clk6 domain; replaces the free-running toggle logic in the top level.

Parameters:
PHASE_CYCLES, 64, clk cycles per select phase (≥ SETTLE_CYCLES+4, ≤ 65535)
SETTLE_CYCLES, 24, cycles after a joyselect change before the sample is taken

Ports:
clk  in  1  system clock (clk6)
reset_n  in  1  asynchronous active-low reset
splitter_en  in  1  1 = two-port splitter mode, 0 = single joystick on port 1
joy_in  in  5  raw pins {left,right,down,up,fire}, active low, asynchronous
joyselect  out  1  splitter select: 1 = port 1, 0 = port 2
joystick1  out  5  port-1 state {left,right,down,up,fire}, active low
joystick2  out  5  port-2 state, same order, active low
scan_done  out  1  one-cycle pulse when a full scan completes

Behaviour:
- Reset (async assert, sync deassert internally):
  - joyselect=1, joystick1=5'h1F, joystick2=5'h1F, scan_done=0.
  - Phase counter=0; FSM in P1_SETTLE; synchroniser flops=5'h1F.
- Input path:
  - joy_in passes through a 2-flop synchroniser.
  - The sample register captures the synchroniser output.
- FSM states: P1_SETTLE, P1_HOLD, P2_SETTLE, P2_HOLD.
- Phase counter cnt counts 0..PHASE_CYCLES-1 within each phase and resets to 0 on every state change into a *_SETTLE state.
- P1_SETTLE (joyselect=1):
  - At cnt==SETTLE_CYCLES-1, joystick1 <= sync value on the next edge; go to P1_HOLD.
- P1_HOLD, at cnt==PHASE_CYCLES-1:
  - If splitter_en=1: go to P2_SETTLE; joyselect <= 0 on the same edge.
  - Else: pulse scan_done; go to P1_SETTLE; joyselect stays 1.
- P2_SETTLE (joyselect=0):
  - At cnt==SETTLE_CYCLES-1, joystick2 <= sync value; go to P2_HOLD.
- P2_HOLD, at cnt==PHASE_CYCLES-1: pulse scan_done; joyselect <= 1; go to P1_SETTLE.
- Scan period: PHASE_CYCLES cycles when disabled, 2×PHASE_CYCLES when enabled.
- Sample latency: pin change to joystick output ≤ 2 sync cycles + one scan period.
- splitter_en transitions:
  - Sampled only at the P1_HOLD exit decision.
  - Falling mid-P2: the P2 phase completes normally.
  - joystick2 is forced to 5'h1F on the cycle after splitter_en is seen low, and held there while low; this override has priority over a coincident P2 sample.
- joyselect is registered, glitch-free, and only changes at phase boundaries.
- No other output changes outside the edges listed above.
- Reset mid-phase: all outputs return to reset values immediately (async).

Optional Feature:
- Macro: JOY_SPLITTER_DEBOUNCE_EN.
- When defined:
  - Each port keeps a 5-bit previous-sample register, reset to 5'h1F.
  - A port output bit updates only when the current sample equals that port's previous sample (two consecutive scans agree).
  - The previous-sample register updates on every sample.
  - The splitter_en-low override of joystick2 also sets port-2 previous to 5'h1F.
- When undefined: outputs take every sample directly; no previous-sample registers are built.

Test Plan:
- Reset, splitter_en=0, joy_in=5'h1E (fire pressed) → joyselect constant 1; joystick1=5'h1E after first sample (cycle SETTLE_CYCLES+2 ≈ 26); joystick2=5'h1F; scan_done every 64 cycles.
- splitter_en=1; bench drives joy_in=5'h17 when joyselect=1, 5'h1D when joyselect=0 → joystick1=5'h17, joystick2=5'h1D; joyselect period 128 cycles, 64 high/64 low; scan_done every 128 cycles on the joyselect 0→1 edge.
- Settle check: bench drives joy_in to the port-1 value for only the first 10 cycles after joyselect→0 → joystick2 still gets the port-2 value (sampled at cnt 23).
- splitter_en drops during P2_SETTLE → joystick2=5'h1F the next cycle and stays there; the phase finishes; joyselect stays 1 from then on.
- reset_n pulsed low mid-P2_HOLD → joyselect=1 and joystick1=joystick2=5'h1F in the same cycle, without waiting for a clk edge; sequence restarts in P1_SETTLE.
- With JOY_SPLITTER_DEBOUNCE_EN: a single-scan glitch joy_in=5'h0F on port 1 → joystick1 unchanged; the same value held for 2 scans → joystick1=5'h0F.
